// File: rtl/booth_pkg.sv
// Shared types and widths for the sequential radix-2 Booth multiplier.
package booth_pkg;

   localparam int unsigned OP_W  = 16;
   localparam int unsigned ACC_W = 17;
   localparam int unsigned CNT_W = 5;

   localparam logic [CNT_W-1:0] CNT_INIT = 5'd16;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StEval,
      StShift,
      StDone
   } state_t;

endpackage

// File: rtl/booth_addsub.sv
// 17-bit modulo adder/subtractor used by the Booth evaluate step.
module booth_addsub
   import booth_pkg::*;
(
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   input  logic             sub,
   output logic [ACC_W-1:0] y
);

   assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential signed 16x16 radix-2 Booth multiplier with a fixed 34-cycle latency.
module booth_seq_ctrl
   import booth_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OP_W-1:0]   multiplicand,
   input  logic [OP_W-1:0]   multiplier,
   output logic              busy,
   output logic              done,
   output logic [2*OP_W-1:0] product
);

   state_t state_q, state_d;

   logic [OP_W-1:0]   cap_m_q, cap_q_q;
   logic [OP_W-1:0]   m_q, q_q;
   logic [ACC_W-1:0]  acc_q;
   logic              q1_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*OP_W-1:0] product_q;

   logic [ACC_W-1:0]  sum;
   logic [ACC_W-1:0]  acc_sh;
   logic [OP_W-1:0]   q_sh;
   logic [CNT_W-1:0]  cnt_dec;

   booth_addsub u_addsub (
      .a   (acc_q),
      .b   ({m_q[OP_W-1], m_q}),
      .sub (q_q[0] & ~q1_q),
      .y   (sum)
   );

   // Arithmetic right shift of the combined {A, Q, Q_1} register.
   assign acc_sh  = {acc_q[ACC_W-1], acc_q[ACC_W-1:1]};
   assign q_sh    = {acc_q[0], q_q[OP_W-1:1]};
   assign cnt_dec = cnt_q - 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StLoad;
         StLoad:  state_d = StEval;
         StEval:  state_d = StShift;
         StShift: state_d = (cnt_dec == '0) ? StDone : StEval;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         StLoad, StEval, StShift: busy = 1'b1;
         StDone:                  done = 1'b1;
         default:                 ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_m_q   <= '0;
         cap_q_q   <= '0;
         m_q       <= '0;
         q_q       <= '0;
         acc_q     <= '0;
         q1_q      <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  cap_m_q <= multiplicand;
                  cap_q_q <= multiplier;
               end
            end
            StLoad: begin
               m_q   <= cap_m_q;
               q_q   <= cap_q_q;
               acc_q <= '0;
               q1_q  <= 1'b0;
               cnt_q <= CNT_INIT;
            end
            StEval: begin
               if (q_q[0] ^ q1_q) acc_q <= sum;
            end
            StShift: begin
               acc_q <= acc_sh;
               q_q   <= q_sh;
               q1_q  <= q_q[0];
               cnt_q <= cnt_dec;
               // Result is taken from the post-shift values on the edge entering DONE.
               if (cnt_dec == '0) product_q <= {acc_sh[OP_W-1:0], q_sh};
            end
            default: ;
         endcase
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl: schedule-level reference model plus literal checks.
module tb_booth_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] multiplicand = '0;
   logic [15:0] multiplier = '0;
   logic        busy, done;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   bit cmp_en = 1'b0;

   // Reference model: cycle index within an operation (0 = idle) and expected product.
   int          m_cyc = 0;
   logic [31:0] m_prod = '0;
   logic [31:0] m_pend = '0;

   always #5 clk = ~clk;

   booth_seq_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cyc  <= 0;
         m_prod <= '0;
      end else if (m_cyc == 0) begin
         if (start) begin
            m_cyc  <= 1;
            m_pend <= 32'(int'($signed(multiplicand)) * int'($signed(multiplier)));
         end
      end else if (m_cyc == 33) begin
         m_cyc  <= 34;
         m_prod <= m_pend;
      end else if (m_cyc == 34) begin
         m_cyc <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (cmp_en) begin
         chk("model_busy", 32'(busy), 32'(m_cyc >= 1 && m_cyc <= 33));
         chk("model_done", 32'(done), 32'(m_cyc == 34));
         chk("model_product", product, m_prod);
      end
   end

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Leaves the bench at the negedge of cycle 1 with scrambled operand inputs.
   task automatic start_op(input logic [15:0] m, input logic [15:0] q);
      @(negedge clk);
      start        = 1'b1;
      multiplicand = m;
      multiplier   = q;
      @(negedge clk);
      cyc          = 1;
      start        = 1'b0;
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
   endtask

   task automatic wait_done(input string name, input logic [31:0] exp);
      while (done !== 1'b1 && cyc < 40) step();
      chk({name, "_latency"}, 32'(cyc), 32'd34);
      chk(name, product, exp);
   endtask

   task automatic quiet_window(input string name);
      int base;
      step();
      base = done_cnt;
      repeat (40) step();
      chk(name, 32'(done_cnt), 32'(base));
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_product", product, 32'd0);
      rst    = 1'b1;
      cmp_en = 1'b1;

      start_op(16'd3, 16'd4);
      wait_done("p_3x4", 32'h0000_000C);
      start_op(-16'sd7, 16'd5);
      wait_done("p_m7x5", 32'hFFFF_FFDD);
      start_op(16'h8000, 16'h8000);
      wait_done("p_min_x_min", 32'h4000_0000);
      start_op(16'h7FFF, 16'h8000);
      wait_done("p_max_x_min", 32'hC000_8000);

      // Start pulsed while busy must be ignored.
      start_op(16'd100, 16'd100);
      while (cyc < 10) step();
      start        = 1'b1;
      multiplicand = 16'd1;
      multiplier   = 16'd1;
      step();
      start = 1'b0;
      wait_done("p_100x100", 32'h0000_2710);
      quiet_window("no_second_done");

      // Reset in the middle of an operation.
      start_op(16'd1234, 16'd567);
      while (cyc < 20) step();
      #2 rst = 1'b0;
      #1;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_done", 32'(done), 32'd0);
      chk("midreset_product", product, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      quiet_window("no_done_after_abort");
      start_op(16'd2, -16'sd3);
      wait_done("p_2xm3", 32'hFFFF_FFFA);

      // Back-to-back: second start sampled at the end of cycle 35.
      start_op(16'd0, 16'h7FFF);
      wait_done("p_0x7fff", 32'h0000_0000);
      step();
      chk("idle_after_done", 32'({busy, done}), 32'd0);
      start        = 1'b1;
      multiplicand = 16'd6;
      multiplier   = 16'd7;
      step();
      cyc          = 1;
      start        = 1'b0;
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
      wait_done("p_6x7", 32'h0000_002A);
      step();
      step();
      chk("done_total", 32'(done_cnt), 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
